control_unit_fsm: RTL and testbench

//  Multi-cycle LEGv8-subset controller that drives dataPath_core's control inputs and reads back IR_out and status.
//  Per instruction: fetch from RAM at PC into IR, decode, execute, optionally access memory, then advance PC.

---
 rtl/control_unit_fsm.sv | 232 +++++++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_fsm.sv
// Multi-cycle LEGv8-subset sequencer for dataPath_core: FETCH/DECODE/EXEC/MEM/BRTEST/HALT, controls registered from next state.
// Define CU_BCOND_EN to decode B.cond plus flag-setting ADDS/SUBS; otherwise those encodings execute as NOPs.
module control_unit_fsm (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_out,
    input  logic [3:0]  status,
    output logic        w_reg,
    output logic        C0,
    output logic        mem_cs,
    output logic        mem_write_en,
    output logic        IR_load,
    output logic        status_load,
    output logic [31:0] k,
    output logic [4:0]  FS,
    output logic [1:0]  PC_FS,
    output logic [1:0]  size,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic        add_tri_sel,
    output logic [1:0]  data_tri_sel,
    output logic        PC_sel,
    output logic        B_Sel,
    output logic        halted
);
    localparam logic [31:0] HALT_WORD = 32'hD440_0000;
    localparam logic [4:0]  FS_AND = 5'b00000;
    localparam logic [4:0]  FS_OR  = 5'b01100;
    localparam logic [4:0]  FS_ADD = 5'b01000;
    localparam logic [4:0]  FS_SUB = 5'b01001;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BRTEST, S_HALT} state_t;

    typedef struct packed {
        logic        w_reg;
        logic        c0;
        logic        mem_cs;
        logic        mem_we;
        logic        ir_load;
        logic        st_load;
        logic [31:0] k;
        logic [4:0]  fs;
        logic [1:0]  pc_fs;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic        add_sel;
        logic [1:0]  data_sel;
        logic        b_sel;
        logic        halted;
    } ctl_t;

    state_t state_q, state_d;
    ctl_t   ctl_q, ctl_d;

    logic       is_r, is_i, is_ld, is_st, is_b, is_cbz, is_cbnz, is_bcond;
    logic       sets_flags, known_op, is_halt, alu_c0, cond_ok, br_taken;
    logic [4:0] alu_fs;
    logic       v_f, c_f, n_f, z_f;

    assign {v_f, c_f, n_f, z_f} = status;

    always_comb begin
        is_r       = 1'b0;
        is_i       = 1'b0;
        is_ld      = 1'b0;
        is_st      = 1'b0;
        sets_flags = 1'b0;
        alu_fs     = FS_ADD;
        alu_c0     = 1'b0;
        case (IR_out[31:21])
            11'b10001011000: is_r = 1'b1;
            11'b11001011000: begin is_r = 1'b1; alu_fs = FS_SUB; alu_c0 = 1'b1; end
            11'b10001010000: begin is_r = 1'b1; alu_fs = FS_AND; end
            11'b10101010000: begin is_r = 1'b1; alu_fs = FS_OR; end
`ifdef CU_BCOND_EN
            11'b10101011000: begin is_r = 1'b1; sets_flags = 1'b1; end
            11'b11101011000: begin is_r = 1'b1; sets_flags = 1'b1; alu_fs = FS_SUB; alu_c0 = 1'b1; end
`endif
            11'b11111000010: is_ld = 1'b1;
            11'b11111000000: is_st = 1'b1;
            default: ;
        endcase
        case (IR_out[31:22])
            10'b1001000100: is_i = 1'b1;
            10'b1101000100: begin is_i = 1'b1; alu_fs = FS_SUB; alu_c0 = 1'b1; end
            10'b1001001000: begin is_i = 1'b1; alu_fs = FS_AND; end
            10'b1011001000: begin is_i = 1'b1; alu_fs = FS_OR; end
            default: ;
        endcase
    end

    assign is_b    = (IR_out[31:26] == 6'b000101);
    assign is_cbz  = (IR_out[31:24] == 8'b10110100);
    assign is_cbnz = (IR_out[31:24] == 8'b10110101);
`ifdef CU_BCOND_EN
    assign is_bcond = (IR_out[31:24] == 8'b01010100);
`else
    assign is_bcond = 1'b0;
`endif
    assign is_halt  = (IR_out == HALT_WORD);
    assign known_op = is_r | is_i | is_ld | is_st | is_b | is_cbz | is_cbnz | is_bcond;

    always_comb begin
        case (IR_out[3:0])
            4'h0: cond_ok = z_f;
            4'h1: cond_ok = ~z_f;
            4'h2: cond_ok = c_f;
            4'h3: cond_ok = ~c_f;
            4'h4: cond_ok = n_f;
            4'h5: cond_ok = ~n_f;
            4'h6: cond_ok = v_f;
            4'h7: cond_ok = ~v_f;
            4'h8: cond_ok = c_f & ~z_f;
            4'h9: cond_ok = ~c_f | z_f;
            4'hA: cond_ok = (n_f == v_f);
            4'hB: cond_ok = (n_f != v_f);
            4'hC: cond_ok = ~z_f & (n_f == v_f);
            4'hD: cond_ok = z_f | (n_f != v_f);
            default: cond_ok = 1'b1;
        endcase
    end

    // Status is read live in BRTEST because it only settles after the EXEC edge that loads it.
    assign br_taken = (is_cbz & z_f) | (is_cbnz & ~z_f) | (is_bcond & cond_ok);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = ctl_q.ir_load ? S_DECODE : S_FETCH;
            S_DECODE: state_d = is_halt ? S_HALT : (known_op ? S_EXEC : S_FETCH);
            S_EXEC:   state_d = (is_ld | is_st) ? S_MEM :
                                ((is_cbz | is_cbnz | is_bcond) ? S_BRTEST : S_FETCH);
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase

        ctl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctl_d.mem_cs   = 1'b1;
                ctl_d.add_sel  = 1'b1;
                ctl_d.data_sel = 2'b11;
                ctl_d.ir_load  = 1'b1;
            end
            S_EXEC: begin
                if (is_r | is_i) begin
                    ctl_d.sa      = IR_out[9:5];
                    ctl_d.fs      = alu_fs;
                    ctl_d.c0      = alu_c0;
                    ctl_d.w_reg   = 1'b1;
                    ctl_d.da      = IR_out[4:0];
                    ctl_d.pc_fs   = 2'b01;
                    ctl_d.st_load = sets_flags;
                    if (is_i) begin
                        ctl_d.k     = {20'd0, IR_out[21:10]};
                        ctl_d.b_sel = 1'b1;
                    end else begin
                        ctl_d.sb = IR_out[20:16];
                    end
                end else if (is_ld | is_st) begin
                    ctl_d.sa    = IR_out[9:5];
                    ctl_d.k     = {{23{IR_out[20]}}, IR_out[20:12]};
                    ctl_d.b_sel = 1'b1;
                    ctl_d.fs    = FS_ADD;
                end else if (is_b) begin
                    ctl_d.k     = {{6{IR_out[25]}}, IR_out[25:0]};
                    ctl_d.pc_fs = 2'b10;
                end else if (is_cbz | is_cbnz) begin
                    ctl_d.sa      = 5'd31;
                    ctl_d.sb      = IR_out[4:0];
                    ctl_d.fs      = FS_OR;
                    ctl_d.st_load = 1'b1;
                end
            end
            S_MEM: begin
                ctl_d        = ctl_q;
                ctl_d.mem_cs = 1'b1;
                ctl_d.pc_fs  = 2'b01;
                if (is_st) begin
                    ctl_d.mem_we   = 1'b1;
                    ctl_d.sb       = IR_out[4:0];
                    ctl_d.data_sel = 2'b01;
                end else begin
                    ctl_d.data_sel = 2'b11;
                    ctl_d.w_reg    = 1'b1;
                    ctl_d.da       = IR_out[4:0];
                end
            end
            S_BRTEST: ctl_d.k = {{13{IR_out[23]}}, IR_out[23:5]};
            S_HALT:   ctl_d.halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    always_comb begin
        PC_FS = ctl_q.pc_fs;
        if (state_q == S_DECODE && !is_halt && !known_op)
            PC_FS = 2'b01;
        else if (state_q == S_BRTEST)
            PC_FS = br_taken ? 2'b10 : 2'b01;
    end

    assign w_reg        = ctl_q.w_reg;
    assign C0           = ctl_q.c0;
    assign mem_cs       = ctl_q.mem_cs;
    assign mem_write_en = ctl_q.mem_we;
    assign IR_load      = ctl_q.ir_load;
    assign status_load  = ctl_q.st_load;
    assign k            = ctl_q.k;
    assign FS           = ctl_q.fs;
    assign size         = 2'b11;
    assign SA           = ctl_q.sa;
    assign SB           = ctl_q.sb;
    assign DA           = ctl_q.da;
    assign add_tri_sel  = ctl_q.add_sel;
    assign data_tri_sel = ctl_q.data_sel;
    assign PC_sel       = 1'b0;
    assign B_Sel        = ctl_q.b_sel;
    assign halted       = ctl_q.halted;
endmodule

// File: tb/tb_control_unit_fsm.sv
// Bench for control_unit_fsm: directed and random instruction words, each expanded into its expected per-cycle control words.
module tb_control_unit_fsm;
    localparam logic [31:0] HALT_WORD = 32'hD440_0000;
`ifdef CU_BCOND_EN
    localparam bit BCOND_EN = 1'b1;
`else
    localparam bit BCOND_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] IR_out;
    logic [3:0]  status;
    logic        w_reg, C0, mem_cs, mem_write_en, IR_load, status_load;
    logic [31:0] k;
    logic [4:0]  FS, SA, SB, DA;
    logic [1:0]  PC_FS, size, data_tri_sel;
    logic        add_tri_sel, PC_sel, B_Sel, halted;

    always #5 clock = ~clock;

    control_unit_fsm dut (
        .clock(clock), .reset(reset), .IR_out(IR_out), .status(status),
        .w_reg(w_reg), .C0(C0), .mem_cs(mem_cs), .mem_write_en(mem_write_en),
        .IR_load(IR_load), .status_load(status_load), .k(k), .FS(FS), .PC_FS(PC_FS),
        .size(size), .SA(SA), .SB(SB), .DA(DA), .add_tri_sel(add_tri_sel),
        .data_tri_sel(data_tri_sel), .PC_sel(PC_sel), .B_Sel(B_Sel), .halted(halted)
    );

    typedef struct packed {
        logic        w;
        logic        c0;
        logic        cs;
        logic        we;
        logic        irl;
        logic        stl;
        logic [31:0] k;
        logic [4:0]  fs;
        logic [1:0]  pcfs;
        logic [1:0]  size;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic        add;
        logic [1:0]  dsel;
        logic        pcsel;
        logic        bsel;
        logic        halt;
    } cw_t;

    cw_t obs;
    assign obs = {w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, k, FS, PC_FS, size,
                  SA, SB, DA, add_tri_sel, data_tri_sel, PC_sel, B_Sel, halted};

    cw_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic check_cw(input string tag, input cw_t got, input cw_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t observed=%h expected=%h", tag, $time, got, want);
        end
    endtask

    function automatic cw_t idle();
        cw_t c = '0;
        c.size = 2'b11;
        return c;
    endfunction

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        return v[bits-1] ? v - (32'd1 << bits) : v;
    endfunction

    // ARM condition semantics: pairs of codes are a test and its inverse; 1110/1111 always hold.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] st);
        bit v = st[3], cf = st[2], n = st[1], z = st[0], r;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && c != 4'hF) r = !r;
        return r;
    endfunction

    function automatic string mnem(input logic [31:0] ir);
        if (ir == HALT_WORD) return "HALT";
        case (ir[31:21])
            11'b10001011000: return "ADD";
            11'b11001011000: return "SUB";
            11'b10001010000: return "AND";
            11'b10101010000: return "ORR";
            11'b10101011000: if (BCOND_EN) return "ADDS";
            11'b11101011000: if (BCOND_EN) return "SUBS";
            11'b11111000010: return "LDUR";
            11'b11111000000: return "STUR";
            default: ;
        endcase
        case (ir[31:22])
            10'b1001000100: return "ADDI";
            10'b1101000100: return "SUBI";
            10'b1001001000: return "ANDI";
            10'b1011001000: return "ORRI";
            default: ;
        endcase
        if (ir[31:26] == 6'b000101) return "B";
        if (ir[31:24] == 8'hB4) return "CBZ";
        if (ir[31:24] == 8'hB5) return "CBNZ";
        if (BCOND_EN && ir[31:24] == 8'h54) return "BCOND";
        return "NOP";
    endfunction

    function automatic logic [4:0] alu_fs(input string base);
        if (base == "ADD") return 5'b01000;
        if (base == "SUB") return 5'b01001;
        if (base == "AND") return 5'b00000;
        if (base == "ORR") return 5'b01100;
        return 5'h1F;
    endfunction

    // Expected control word for every cycle of one instruction, FETCH first.
    task automatic model(input logic [31:0] ir, input logic [3:0] st);
        string      m = mnem(ir);
        cw_t        f = idle(), d = idle(), e = idle(), x = idle();
        logic [4:0] fs;
        f.cs = 1'b1; f.add = 1'b1; f.dsel = 2'b11; f.irl = 1'b1;
        exp_q.push_back(f);
        if (m == "NOP") d.pcfs = 2'b01;
        exp_q.push_back(d);
        if (m == "NOP") return;
        if (m == "HALT") begin
            x.halt = 1'b1;
            repeat (20) exp_q.push_back(x);
            return;
        end
        fs = alu_fs(m.substr(0, 2));
        if (fs != 5'h1F) begin
            e.fs = fs; e.c0 = (m.substr(0, 2) == "SUB");
            e.sa = ir[9:5]; e.w = 1'b1; e.da = ir[4:0]; e.pcfs = 2'b01;
            if (m.len() == 4 && m.substr(3, 3) == "I") begin
                e.k = {20'd0, ir[21:10]}; e.bsel = 1'b1;
            end else begin
                e.sb = ir[20:16]; e.stl = (m.len() == 4);
            end
            exp_q.push_back(e);
        end else if (m == "LDUR" || m == "STUR") begin
            e.sa = ir[9:5]; e.k = sx({23'd0, ir[20:12]}, 9); e.bsel = 1'b1; e.fs = 5'b01000;
            exp_q.push_back(e);
            x = e; x.cs = 1'b1; x.pcfs = 2'b01;
            if (m == "STUR") begin x.we = 1'b1; x.sb = ir[4:0]; x.dsel = 2'b01; end
            else begin x.dsel = 2'b11; x.w = 1'b1; x.da = ir[4:0]; end
            exp_q.push_back(x);
        end else if (m == "B") begin
            e.k = sx({6'd0, ir[25:0]}, 26); e.pcfs = 2'b10;
            exp_q.push_back(e);
        end else begin
            if (m != "BCOND") begin
                e.sa = 5'd31; e.sb = ir[4:0]; e.fs = 5'b01100; e.stl = 1'b1;
            end
            exp_q.push_back(e);
            x.k = sx({13'd0, ir[23:5]}, 19);
            if (m == "CBZ") x.pcfs = st[0] ? 2'b10 : 2'b01;
            else if (m == "CBNZ") x.pcfs = st[0] ? 2'b01 : 2'b10;
            else x.pcfs = cond_holds(ir[3:0], st) ? 2'b10 : 2'b01;
            exp_q.push_back(x);
        end
    endtask

    // Entered just after the edge that starts FETCH; IR is loaded by the edge that ends it.
    task automatic run_instr(input logic [31:0] ir, input logic [3:0] st);
        string m = mnem(ir);
        model(ir, st);
        @(negedge clock);
        check_cw({m, ".fetch"}, obs, exp_q.pop_front());
        @(posedge clock);
        #1;
        IR_out = ir;
        status = st;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            check_cw(m, obs, exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_cw("reset", obs, idle());
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    logic [31:0] w;
    logic [31:0] stur_w;

    initial begin
        reset  = 1'b0;
        IR_out = '0;
        status = '0;
        do_reset();

        run_instr({10'b1011001000, 12'd10, 5'd31, 5'd0}, 4'h0);          // ORRI X0,X31,#10
        run_instr({11'b10001011000, 5'd0, 6'd0, 5'd0, 5'd1}, 4'h0);       // ADD X1,X0,X0
        run_instr({10'b1101000100, 12'd5, 5'd1, 5'd2}, 4'h0);             // SUBI X2,X1,#5
        run_instr({11'b11111000000, 9'd8, 2'b00, 5'd31, 5'd2}, 4'h0);     // STUR X2,[X31,#8]
        run_instr({11'b11111000010, 9'd8, 2'b00, 5'd31, 5'd3}, 4'h0);     // LDUR X3,[X31,#8]
        run_instr({11'b11111000010, 9'h1F8, 2'b00, 5'd4, 5'd5}, 4'h0);    // LDUR negative offset
        run_instr({8'hB4, 19'h7FFFD, 5'd31}, 4'h1);                       // CBZ X31,#-3 taken
        run_instr({8'hB5, 19'd1, 5'd31}, 4'h1);                           // CBNZ X31 not taken
        run_instr({6'b000101, 26'd2}, 4'h0);                              // B #2
        run_instr({6'b000101, 26'h3FFFFFE}, 4'h0);                        // B #-2
        run_instr({11'b11101011000, 5'd0, 6'd0, 5'd0, 5'd31}, 4'h0);      // SUBS X31,X0,X0
        run_instr({8'h54, 19'd2, 1'b0, 4'h0}, 4'h1);                      // B.EQ +2 with Z set
        run_instr(32'h0000_0000, 4'h0);                                   // unrecognised

        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            case ($urandom_range(0, 17))
                0:  w[31:21] = 11'b10001011000;
                1:  w[31:21] = 11'b11001011000;
                2:  w[31:21] = 11'b10001010000;
                3:  w[31:21] = 11'b10101010000;
                4:  w[31:22] = 10'b1001000100;
                5:  w[31:22] = 10'b1101000100;
                6:  w[31:22] = 10'b1001001000;
                7:  w[31:22] = 10'b1011001000;
                8:  w[31:21] = 11'b11111000010;
                9:  w[31:21] = 11'b11111000000;
                10: w[31:26] = 6'b000101;
                11: w[31:24] = 8'hB4;
                12: w[31:24] = 8'hB5;
                13: w[31:24] = 8'h54;
                14: w[31:21] = 11'b10101011000;
                15: w[31:21] = 11'b11101011000;
                default: ;
            endcase
            if (w == HALT_WORD) w = 32'd0;
            run_instr(w, 4'($urandom_range(0, 15)));
        end

        run_instr(HALT_WORD, 4'h0);
        do_reset();
        run_instr({10'b1011001000, 12'd10, 5'd31, 5'd0}, 4'h0);

        // Abort a store in its MEM cycle: every control must drop without waiting for an edge.
        stur_w = {11'b11111000000, 9'd16, 2'b00, 5'd31, 5'd7};
        model(stur_w, 4'h0);
        @(negedge clock);
        check_cw("abort.fetch", obs, exp_q.pop_front());
        @(posedge clock);
        #1;
        IR_out = stur_w;
        repeat (2) begin
            @(negedge clock);
            check_cw("abort.pre", obs, exp_q.pop_front());
        end
        @(posedge clock);
        #2;
        check_cw("abort.mem", obs, exp_q.pop_front());
        reset = 1'b0;
        #1;
        check_cw("abort.async", obs, idle());
        exp_q.delete();
        do_reset();
        run_instr({11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3}, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
